hyper_trap_arb: RTL and testbench

//  Collects hypervisor trap requests and issues them one at a time to the hypervisor entry controller.

---
 rtl/hyper_trap_arb_pkg.sv | 24 ++
 rtl/hyper_trap_arb_prio_enc.sv | 21 ++
 rtl/hyper_trap_arb.sv | 194 +++++++++++++++++++
 tb/tb_hyper_trap_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_trap_arb_pkg.sv
// Hypervisor trap arbiter shared types.
// FSM encodings and trap port constants.
package hyper_trap_arb_pkg;

  localparam int HYPER_TRAP_PORT_W = 7;
  localparam logic [6:0] HYPER_TRAP_EXT_BASE = 7'h40;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ISSUE   = 3'd1,
    ARB_WAIT_IN = 3'd2,
    ARB_IN_HYP  = 3'd3,
    ARB_HOLD    = 3'd4
  } arb_state_t;

  // Port number of external source i.
  function automatic logic [6:0] ext_port(
    input logic [6:0] base,
    input logic [6:0] i
  );
    return base + i;
  endfunction

endpackage

// File: rtl/hyper_trap_arb_prio_enc.sv
// Fixed-priority encoder, lowest index wins.
// Purely combinational.
module hyper_trap_arb_prio_enc #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/hyper_trap_arb.sv
// Hypervisor trap arbiter: latches trap events,
// grants one at a time, tracks the hypervisor lifecycle.
module hyper_trap_arb
  import hyper_trap_arb_pkg::*;
#(
  parameter int         NUM_SRC      = 4,
  parameter logic [6:0] EXT_BASE     = HYPER_TRAP_EXT_BASE,
  parameter int         ENTER_TMO    = 64,
  parameter int         HOLDOFF_INSN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic               cpu_sync,
  input  logic               hyper_mode,
  input  logic               sw_trap_req,
  input  logic [5:0]         sw_trap_port,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               err_clr,
  output logic               enter_req,
  output logic [6:0]         trap_port,
  output logic [6:0]         last_cause,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic               sw_overrun,
  output logic               tmo_err
);

  localparam int NR = NUM_SRC + 1;
  localparam int IW = $clog2(NR);
  localparam int TW =
    (ENTER_TMO > 1) ? $clog2(ENTER_TMO) : 1;
  localparam int HW =
    (HOLDOFF_INSN > 0) ? $clog2(HOLDOFF_INSN + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ENTER_TMO - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_INSN);

  if (int'(EXT_BASE) + NUM_SRC - 1 > 127) begin : g_port_chk
    $error("hyper_trap_arb: EXT_BASE+NUM_SRC-1 exceeds 7'h7F");
  end
  if (NUM_SRC < 1 || NUM_SRC > 16) begin : g_src_chk
    $error("hyper_trap_arb: NUM_SRC must be 1..16");
  end

  arb_state_t state, state_nxt;

  logic [NUM_SRC-1:0] pend;
  logic               sw_pend;
  logic [5:0]         sw_port_q;
  logic [TW-1:0]      tmo_cnt, tmo_nxt;
  logic [HW-1:0]      hold_cnt, hold_nxt;
  logic               enter_nxt;
  logic               grant;
  logic               tmo_set;

  logic [NR-1:0]      cand;
  logic               cand_vld;
  logic [IW-1:0]      cand_idx;
  logic [NR-1:0]      clr;
  logic [6:0]         win_port;
  logic               sw_acc;
  logic               sw_drop;

  // Writes during hyper_mode are exits and belong to hyper_ctrl.
  assign sw_acc  = sw_trap_req & ~sw_pend & ~hyper_mode;
  assign sw_drop = sw_trap_req &  sw_pend & ~hyper_mode;

  assign cand = {pend & src_en, sw_pend};

  hyper_trap_arb_prio_enc #(
    .N  (NR),
    .IW (IW)
  ) u_enc (
    .req   (cand),
    .valid (cand_vld),
    .idx   (cand_idx)
  );

  assign win_port = (cand_idx == '0)
    ? {1'b0, sw_port_q}
    : ext_port(EXT_BASE, 7'(cand_idx) - 7'd1);

  assign clr = grant ? (NR'(1) << cand_idx) : '0;

  assign pending = pend;

  // Next-state, grant decision and counter updates.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    enter_nxt = enter_req;
    tmo_nxt   = tmo_cnt;
    hold_nxt  = hold_cnt;
    tmo_set   = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (!hyper_mode && cand_vld && ready) begin
          grant     = 1'b1;
          enter_nxt = 1'b1;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (ready) begin
          enter_nxt = 1'b0;
          tmo_nxt   = '0;
          state_nxt = ARB_WAIT_IN;
        end
      end
      ARB_WAIT_IN: begin
        if (hyper_mode) begin
          state_nxt = ARB_IN_HYP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_set   = 1'b1;
          state_nxt = ARB_IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      ARB_IN_HYP: begin
        if (!hyper_mode) begin
          hold_nxt  = '0;
          state_nxt = (HOLDOFF_INSN == 0)
            ? ARB_IDLE : ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (hyper_mode) begin
          state_nxt = ARB_IN_HYP;
        end else begin
          if (ready && cpu_sync && hold_cnt != HOLD_MAX)
            hold_nxt = hold_cnt + 1'b1;
          if (hold_nxt == HOLD_MAX)
            state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // FSM state, handshake output and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      busy      <= 1'b0;
      enter_req <= 1'b0;
      tmo_cnt   <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ARB_IDLE);
      enter_req <= enter_nxt;
      tmo_cnt   <= tmo_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  // Winner port capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_port  <= '0;
      last_cause <= '0;
    end else if (grant) begin
      trap_port  <= win_port;
      last_cause <= win_port;
    end
  end

  // Pending latches; a new event beats its own grant clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      sw_pend   <= 1'b0;
      sw_port_q <= '0;
    end else begin
      pend    <= (pend & ~clr[NR-1:1]) | src_req;
      sw_pend <= (sw_pend & ~clr[0]) | sw_acc;
      if (sw_acc) sw_port_q <= sw_trap_port;
    end
  end

  // Sticky error flags; a fresh error beats err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_overrun <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      sw_overrun <= sw_drop | (sw_overrun & ~err_clr);
      tmo_err    <= tmo_set | (tmo_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_hyper_trap_arb.sv
// Bench for hyper_trap_arb: scenario tasks plus
// a grant scoreboard fed by expected trap ports.
module tb_hyper_trap_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b1;
  logic       cpu_sync = 1'b0;
  logic       hyper_mode = 1'b0;
  logic       sw_trap_req = 1'b0;
  logic [5:0] sw_trap_port = 6'h00;
  logic [3:0] src_req = 4'h0;
  logic [3:0] src_en = 4'hF;
  logic       err_clr = 1'b0;
  logic       enter_req;
  logic [6:0] trap_port;
  logic [6:0] last_cause;
  logic [3:0] pending;
  logic       busy;
  logic       sw_overrun;
  logic       tmo_err;

  int checks = 0;
  int errors = 0;
  logic [6:0] sb[$];
  logic enter_q = 1'b0;

  hyper_trap_arb #(
    .NUM_SRC      (4),
    .EXT_BASE     (7'h40),
    .ENTER_TMO    (64),
    .HOLDOFF_INSN (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .cpu_sync     (cpu_sync),
    .hyper_mode   (hyper_mode),
    .sw_trap_req  (sw_trap_req),
    .sw_trap_port (sw_trap_port),
    .src_req      (src_req),
    .src_en       (src_en),
    .err_clr      (err_clr),
    .enter_req    (enter_req),
    .trap_port    (trap_port),
    .last_cause   (last_cause),
    .pending      (pending),
    .busy         (busy),
    .sw_overrun   (sw_overrun),
    .tmo_err      (tmo_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every new enter_req must match the oldest expected port.
  always @(negedge clk) begin
    if (!reset && enter_req && !enter_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: grant port %h, none expected",
                 trap_port);
      end else begin
        if (trap_port !== sb[0]) begin
          errors++;
          $display("FAIL sb_port: got %h want %h", trap_port, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
    enter_q <= enter_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From ISSUE with ready=1: enter, leave, one guest fetch -> IDLE.
  task automatic retire();
    tick();
    hyper_mode = 1'b1;
    tick();
    hyper_mode = 1'b0;
    tick();
    cpu_sync = 1'b1;
    tick();
    cpu_sync = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({enter_req, busy, sw_overrun, tmo_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_flags: got %b want 0000",
               {enter_req, busy, sw_overrun, tmo_err});
    end
    checks++;
    if ({trap_port, last_cause, pending} !== 18'h0) begin
      errors++;
      $display("FAIL rst_regs: got %h/%h/%b want 0",
               trap_port, last_cause, pending);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sw_basic();
    sw_trap_req  = 1'b1;
    sw_trap_port = 6'h05;
    sb.push_back(7'h05);
    tick();
    sw_trap_req = 1'b0;
    checks++;
    if (enter_req !== 1'b0) begin
      errors++;
      $display("FAIL t1_early: enter_req=%b want 0", enter_req);
    end
    tick();
    checks++;
    if (enter_req !== 1'b1 || trap_port !== 7'h05) begin
      errors++;
      $display("FAIL t1_grant: enter=%b port=%h want 1/05",
               enter_req, trap_port);
    end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (enter_req !== 1'b1 || trap_port !== 7'h05) begin
        errors++;
        $display("FAIL t1_hold%0d: enter=%b port=%h want 1/05",
                 i, enter_req, trap_port);
      end
    end
    ready = 1'b1;
    retire();
    checks++;
    if (busy !== 1'b0 || last_cause !== 7'h05) begin
      errors++;
      $display("FAIL t1_done: busy=%b cause=%h want 0/05",
               busy, last_cause);
    end
  endtask

  task automatic test_two_src();
    src_req = 4'b0101;
    sb.push_back(7'h40);
    sb.push_back(7'h42);
    tick();
    src_req = 4'b0000;
    tick();
    checks++;
    if (trap_port !== 7'h40 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL t2_first: port=%h pend=%b want 40/0100",
               trap_port, pending);
    end
    tick();
    hyper_mode = 1'b1;
    tick();
    hyper_mode = 1'b0;
    tick();
    tick();
    checks++;
    if (enter_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t2_holdoff: enter=%b busy=%b want 0/1",
               enter_req, busy);
    end
    cpu_sync = 1'b1;
    tick();
    cpu_sync = 1'b0;
    tick();
    checks++;
    if (enter_req !== 1'b1 || trap_port !== 7'h42 ||
        pending !== 4'b0000) begin
      errors++;
      $display("FAIL t2_second: enter=%b port=%h pend=%b want 1/42/0",
               enter_req, trap_port, pending);
    end
    retire();
  endtask

  task automatic test_overrun();
    sw_trap_req  = 1'b1;
    sw_trap_port = 6'h11;
    sb.push_back(7'h11);
    tick();
    sw_trap_port = 6'h22;
    tick();
    sw_trap_req = 1'b0;
    checks++;
    if (trap_port !== 7'h11 || sw_overrun !== 1'b1) begin
      errors++;
      $display("FAIL t3_ovr: port=%h ovr=%b want 11/1",
               trap_port, sw_overrun);
    end
    ready   = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (sw_overrun !== 1'b0) begin
      errors++;
      $display("FAIL t3_clr: ovr=%b want 0", sw_overrun);
    end
    ready = 1'b1;
    retire();
    tick();
    checks++;
    if (enter_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t3_dropped: enter=%b busy=%b want 0/0",
               enter_req, busy);
    end
  endtask

  task automatic test_timeout();
    src_req = 4'b1000;
    sb.push_back(7'h43);
    tick();
    src_req = 4'b0000;
    tick();
    tick();
    for (int i = 0; i < 63; i++) tick();
    checks++;
    if (tmo_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t4_pre: tmo=%b busy=%b want 0/1", tmo_err, busy);
    end
    tick();
    checks++;
    if (tmo_err !== 1'b1 || busy !== 1'b0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL t4_tmo: tmo=%b busy=%b pend=%b want 1/0/0000",
               tmo_err, busy, pending);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (tmo_err !== 1'b0) begin
      errors++;
      $display("FAIL t4_clr: tmo=%b want 0", tmo_err);
    end
  endtask

  task automatic test_mask();
    src_en  = 4'b1101;
    src_req = 4'b0010;
    tick();
    src_req = 4'b0000;
    tick();
    tick();
    checks++;
    if (pending !== 4'b0010 || enter_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_masked: pend=%b enter=%b busy=%b want 0010/0/0",
               pending, enter_req, busy);
    end
    sb.push_back(7'h41);
    src_en = 4'b1111;
    tick();
    checks++;
    if (enter_req !== 1'b1 || trap_port !== 7'h41 ||
        pending !== 4'b0000) begin
      errors++;
      $display("FAIL t5_grant: enter=%b port=%h pend=%b want 1/41/0",
               enter_req, trap_port, pending);
    end
    retire();
  endtask

  task automatic test_reset_mid();
    src_req = 4'b1011;
    sb.push_back(7'h40);
    tick();
    src_req = 4'b0000;
    tick();
    tick();
    checks++;
    if (pending !== 4'b1010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t6_pre: pend=%b busy=%b want 1010/1",
               pending, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({enter_req, busy, pending} !== 6'b0 ||
        {trap_port, last_cause} !== 14'h0) begin
      errors++;
      $display("FAIL t6_async: enter=%b busy=%b pend=%b port=%h want 0",
               enter_req, busy, pending, trap_port);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (enter_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_after: enter=%b busy=%b want 0/0",
               enter_req, busy);
    end
  endtask

  initial begin
    test_reset();
    test_sw_basic();
    test_two_src();
    test_overrun();
    test_timeout();
    test_mask();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left: %0d grants outstanding, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
